// File: rtl/multdiv_ctrl_if.sv
// Shared types and the execute-stage <-> HI/LO multi-cycle unit interface.
// The type package comes first so the interface and controller can import it.
package multdiv_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MC_MULT  = 3'd0,
    MC_MULTU = 3'd1,
    MC_DIV   = 3'd2,
    MC_DIVU  = 3'd3,
    MC_MADD  = 3'd4,
    MC_MADDU = 3'd5,
    MC_MSUB  = 3'd6,
    MC_MSUBU = 3'd7
  } multicycle_t;

  typedef struct packed {
    logic  valid;
    word_t data;
  } hilo_write_req;
endpackage

interface multdiv_if;
  import multdiv_pkg::*;

  logic          req_valid;
  multicycle_t   req_op;
  word_t         src_a;
  word_t         src_b;
  word_t         hi_in;
  word_t         lo_in;
  logic          flush;
  logic          stall;
  hilo_write_req hi_wr;
  hilo_write_req lo_wr;

  modport master (
    output req_valid, req_op,
    output src_a, src_b,
    output hi_in, lo_in,
    output flush,
    input  stall,
    input  hi_wr, lo_wr
  );

  modport slave (
    input  req_valid, req_op,
    input  src_a, src_b,
    input  hi_in, lo_in,
    input  flush,
    output stall,
    output hi_wr, lo_wr
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// HI/LO multi-cycle sequencer: fixed-latency multiply, 32-step restoring divide.
// Define MULTDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic     clk,
  input  logic     reset,
  multdiv_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] res_q;
  multicycle_t op_q;
  word_t       a_q, b_q;
  logic        neg_q_q, neg_r_q;
`ifdef MULTDIV_MADD_EN
  word_t       hi_q, lo_q;
`endif

  logic legal, is_div, accept, div_sgn;

  always_comb begin
    is_div  = (bus.req_op == MC_DIV) ||
              (bus.req_op == MC_DIVU);
    div_sgn = (bus.req_op == MC_DIV);
`ifdef MULTDIV_MADD_EN
    legal   = 1'b1;
`else
    legal   = ~bus.req_op[2];
`endif
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && legal) begin
          accept  = 1'b1;
          state_d = is_div ? S_DIV : S_MUL;
        end
      end
      S_MUL: if (cnt_q == 6'd0) state_d = S_DONE;
      S_DIV: if (cnt_q == 6'd0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      accept  = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Multiply: sign-extend to 64 bits so one multiplier serves both forms.
  logic        mul_sgn;
  logic [63:0] sx_a, sx_b, prod, mul_res;

  always_comb begin
    mul_sgn = (op_q == MC_MULT) ||
              (op_q == MC_MADD) ||
              (op_q == MC_MSUB);
    sx_a = {{32{a_q[31] & mul_sgn}}, a_q};
    sx_b = {{32{b_q[31] & mul_sgn}}, b_q};
    prod = sx_a * sx_b;
`ifdef MULTDIV_MADD_EN
    unique case (op_q)
      MC_MADD, MC_MADDU: mul_res = {hi_q, lo_q} + prod;
      MC_MSUB, MC_MSUBU: mul_res = {hi_q, lo_q} - prod;
      default:           mul_res = prod;
    endcase
`else
    mul_res = prod;
`endif
  end

  // Divide step: res_q holds {partial remainder, dividend/quotient shift}.
  logic [32:0] rem_sh, diff;
  logic        ge;
  word_t       rem_n, quo_n, rem_f, quo_f;

  always_comb begin
    rem_sh = {res_q[63:32], res_q[31]};
    diff   = rem_sh - {1'b0, b_q};
    ge     = ~diff[32];
    rem_n  = ge ? diff[31:0] : rem_sh[31:0];
    quo_n  = {res_q[30:0], ge};
    quo_f  = neg_q_q ? (32'd0 - quo_n) : quo_n;
    rem_f  = neg_r_q ? (32'd0 - rem_n) : rem_n;
  end

  function automatic word_t mag(input word_t v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 6'd0;
      res_q   <= 64'd0;
      op_q    <= MC_MULT;
      a_q     <= '0;
      b_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`ifdef MULTDIV_MADD_EN
      hi_q    <= '0;
      lo_q    <= '0;
`endif
    end else if (accept) begin
      op_q <= bus.req_op;
      if (is_div) begin
        cnt_q   <= 6'd31;
        res_q   <= {32'd0, mag(bus.src_a, div_sgn)};
        b_q     <= mag(bus.src_b, div_sgn);
        neg_q_q <= div_sgn & (bus.src_a[31] ^ bus.src_b[31]);
        neg_r_q <= div_sgn & bus.src_a[31];
      end else begin
        cnt_q <= 6'(MUL_CYCLES - 1);
        a_q   <= bus.src_a;
        b_q   <= bus.src_b;
      end
`ifdef MULTDIV_MADD_EN
      hi_q <= bus.hi_in;
      lo_q <= bus.lo_in;
`endif
    end else if (state_q == S_MUL) begin
      res_q <= mul_res;
      if (cnt_q != 6'd0) cnt_q <= cnt_q - 6'd1;
    end else if (state_q == S_DIV) begin
      if (cnt_q != 6'd0) begin
        res_q <= {rem_n, quo_n};
        cnt_q <= cnt_q - 6'd1;
      end else begin
        res_q <= {rem_f, quo_f};
      end
    end
  end

  logic wr_en, take;

  always_comb begin
    take  = (state_q == S_IDLE) & bus.req_valid & legal;
    wr_en = (state_q == S_DONE) & ~bus.flush & ~reset;
    bus.stall = ~reset & ~bus.flush &
                (take | (state_q == S_MUL) | (state_q == S_DIV));
    bus.hi_wr.valid = wr_en;
    bus.hi_wr.data  = wr_en ? res_q[63:32] : '0;
    bus.lo_wr.valid = wr_en;
    bus.lo_wr.data  = wr_en ? res_q[31:0] : '0;
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl.
// Follows MULTDIV_MADD_EN in the same way as the design.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  multdiv_if bif ();

  multdiv_ctrl #(.MUL_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " stall"}, 64'(bif.stall), 64'd0);
    chk({tag, " hi_wr"}, 64'(bif.hi_wr), 64'd0);
    chk({tag, " lo_wr"}, 64'(bif.lo_wr), 64'd0);
  endtask

  task automatic run(input string tag, input multicycle_t op,
                     input word_t a, input word_t b,
                     input word_t hi, input word_t lo,
                     input int exp_stall,
                     input word_t exp_hi, input word_t exp_lo);
    int cyc;
    logic early_wr;
    @(posedge clk); #1;
    bif.flush = 1'b0;
    bif.req_valid = 1'b1;
    bif.req_op = op;
    bif.src_a = a;
    bif.src_b = b;
    bif.hi_in = hi;
    bif.lo_in = lo;
    #1;
    cyc = 0;
    early_wr = 1'b0;
    while (bif.stall === 1'b1 && cyc < 200) begin
      cyc++;
      if (bif.hi_wr.valid !== 1'b0 || bif.lo_wr.valid !== 1'b0)
        early_wr = 1'b1;
      @(posedge clk); #1;
      bif.src_a = ~a;
      bif.src_b = b ^ 32'h5A5A_0001;
      bif.hi_in = ~hi;
      bif.lo_in = ~lo;
      #1;
    end
    chk({tag, " stall cycles"}, 64'(cyc), 64'(exp_stall));
    chk({tag, " early write"}, 64'(early_wr), 64'd0);
    chk({tag, " valid"},
        {62'd0, bif.hi_wr.valid, bif.lo_wr.valid}, 64'd3);
    chk({tag, " HI"}, 64'(bif.hi_wr.data), 64'(exp_hi));
    chk({tag, " LO"}, 64'(bif.lo_wr.data), 64'(exp_lo));
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    #1;
    chk_quiet({tag, " idle"});
  endtask

  initial begin
    reset = 1'b1;
    bif.req_valid = 1'b0;
    bif.req_op = MC_MULT;
    bif.src_a = '0;
    bif.src_b = '0;
    bif.hi_in = '0;
    bif.lo_in = '0;
    bif.flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_quiet("post reset");

    run("MULT", MC_MULT, 32'hFFFF_FFFE, 32'h3, 0, 0,
        4, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("MULTU", MC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
        4, 32'hFFFF_FFFE, 32'h0000_0001);
    run("DIV -7/2", MC_DIV, 32'hFFFF_FFF9, 32'h2, 0, 0,
        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("DIV min/-1", MC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
        33, 32'h0, 32'h8000_0000);
    run("DIVU 5/0", MC_DIVU, 32'h5, 32'h0, 0, 0,
        33, 32'h5, 32'hFFFF_FFFF);
    run("DIVU 100/7", MC_DIVU, 32'd100, 32'd7, 0, 0,
        33, 32'd2, 32'd14);

`ifdef MULTDIV_MADD_EN
    run("MADDU", MC_MADDU, 32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF,
        4, 32'h1, 32'h0);
    run("MSUB", MC_MSUB, 32'h1, 32'h1, 32'h0, 32'h0,
        4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("MADD", MC_MADD, 32'hFFFF_FFFE, 32'h3, 32'h0, 32'd10,
        4, 32'h0, 32'd4);
`else
    @(posedge clk); #1;
    bif.req_valid = 1'b1;
    bif.req_op = MC_MADDU;
    bif.src_a = 32'h1;
    bif.src_b = 32'h1;
    bif.lo_in = 32'hFFFF_FFFF;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_quiet("MADDU off");
      @(posedge clk); #2;
    end
    bif.req_op = MC_MSUB;
    bif.lo_in = 32'h0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_quiet("MSUB off");
      @(posedge clk); #2;
    end
    bif.req_valid = 1'b0;
`endif

    // Flush on the 10th DIV cycle, then accept a multiply right after.
    @(posedge clk); #1;
    bif.req_valid = 1'b1;
    bif.req_op = MC_DIVU;
    bif.src_a = 32'd1000;
    bif.src_b = 32'd3;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("flush pre stall", 64'(bif.stall), 64'd1);
      @(posedge clk); #2;
    end
    chk("flush pre stall", 64'(bif.stall), 64'd1);
    bif.flush = 1'b1;
    #1;
    chk_quiet("flush cycle");
    run("MULTU after flush", MC_MULTU, 32'd2, 32'd3, 0, 0,
        4, 32'd0, 32'd6);

    // Reset during MUL.
    @(posedge clk); #1;
    bif.req_valid = 1'b1;
    bif.req_op = MC_MULT;
    bif.src_a = 32'd7;
    bif.src_b = 32'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bif.req_valid = 1'b0;
    #1;
    chk_quiet("reset mid MUL");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      chk_quiet("after reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
